// File: rtl/acc_result_reader_if.sv
// Bundles the result-memory read port and the output word stream of
// acc_result_reader. The master side is the reader itself, the slave side
// is the memory plus the egress consumer.
//
// Handshake: a word moves on a cycle where m_valid and m_ready are both 1
// at the rising clock edge. Once m_valid is raised it stays high, and
// m_data / m_last_col / m_last_frame stay unchanged, until that transfer
// happens. m_ready may change freely and never depends combinationally on
// m_valid. The read side has no handshake: data_i must be valid RD_LAT
// cycles after the cycle where ren was 1.
interface acc_result_reader_if #(
  parameter int DW = 64,
  parameter int AW = 16
) ();
  logic          ren;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] data_i;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last_col;
  logic          m_last_frame;

  modport master (
    output ren, rd_ptr, m_valid, m_data, m_last_col, m_last_frame,
    input  data_i, m_ready
  );

  modport slave (
    input  ren, rd_ptr, m_valid, m_data, m_last_col, m_last_frame,
    output data_i, m_ready
  );
endinterface

// File: rtl/acc_result_reader.sv
// Drains the accelerator result memory one frame at a time. Reads are
// issued only against write credit (4 words per 256-bit line written) and
// only when the skid FIFO can absorb every read already in flight. Words
// leave on a valid/ready stream tagged with column and frame boundaries.
module acc_result_reader #(
  parameter int DW         = 64,
  parameter int AW         = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int WPC        = 28,
  parameter int COLS       = 56,
  parameter int CHNLS      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 wr_line,
  acc_result_reader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf,
  output logic [1:0]           dbg_state
);

  localparam int TOTAL = WPC * COLS * CHNLS;
  localparam int NCOL  = COLS * CHNLS;
  localparam int TW    = $clog2(TOTAL + 1);
  localparam int WW    = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int CW    = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int PW    = $clog2(FIFO_DEPTH + RD_LAT + 1);

  localparam logic [AW+1:0] AVAIL_MAX = {2'b01, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [AW:0]     avail;
  logic [AW+1:0]   avail_sum;
  logic [TW-1:0]   issued;
  logic [AW-1:0]   rd_ptr_q;
  logic [RD_LAT-1:0] pipe;
  logic [PW-1:0]   inflight;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [FAW-1:0]  wp;
  logic [FAW-1:0]  rp;
  logic [PW-1:0]   occ;
  logic [WW-1:0]   word_cnt;
  logic [CW-1:0]   col_cnt;
  logic            ren_int;
  logic            push;
  logic            pop;
  logic            start_run;
  logic            last_col;
  logic            last_frame;

  assign start_run = (state == S_IDLE) && start;
  assign push      = pipe[RD_LAT-1];
  assign pop       = bus.m_valid && bus.m_ready;

  // Reads already issued but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + PW'(pipe[i]);
    end
  end

  // A read goes out only with credit, frame words left and guaranteed FIFO room.
  assign ren_int = (state == S_RUN) && (avail != '0) && (issued < TW'(TOTAL)) &&
                   ((occ + inflight) < PW'(FIFO_DEPTH));

  // Next credit value; a line and a read in the same cycle net +3.
  assign avail_sum = {1'b0, avail} + {{(AW-1){1'b0}}, wr_line, 2'b00}
                   - {{(AW+1){1'b0}}, ren_int};

  assign last_col   = bus.m_valid && (word_cnt == WW'(WPC - 1));
  assign last_frame = last_col && (col_cnt == CW'(NCOL - 1));

  assign bus.ren          = ren_int;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.m_valid      = (occ != '0);
  assign bus.m_data       = mem[rp];
  assign bus.m_last_col   = last_col;
  assign bus.m_last_frame = last_frame;
  assign dbg_state        = state;

  // Credit counter runs in every state; saturates and latches the error on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail   <= '0;
      err_ovf <= 1'b0;
    end else if (avail_sum > AVAIL_MAX) begin
      avail   <= AVAIL_MAX[AW:0];
      err_ovf <= 1'b1;
    end else begin
      avail   <= avail_sum[AW:0];
    end
  end

  // Valid-bit delay line matching the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= ren_int;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Skid FIFO: returning read data in, stream words out; no bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) begin
        mem[wp] <= bus.data_i;
        wp      <= wp + FAW'(1);
      end
      if (pop) begin
        rp <= rp + FAW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + PW'(1);
        2'b01:   occ <= occ - PW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Word-in-column and column position of the word at the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      col_cnt  <= '0;
    end else if (start_run) begin
      word_cnt <= '0;
      col_cnt  <= '0;
    end else if (pop) begin
      if (word_cnt == WW'(WPC - 1)) begin
        word_cnt <= '0;
        col_cnt  <= (col_cnt == CW'(NCOL - 1)) ? '0 : col_cnt + CW'(1);
      end else begin
        word_cnt <= word_cnt + WW'(1);
      end
    end
  end

  // Frame sequencing, read address/issue count and the registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      issued   <= '0;
      rd_ptr_q <= '0;
    end else begin
      done <= 1'b0;
      if (ren_int) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        issued   <= issued + TW'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            issued <= '0;
          end
        end
        S_RUN: begin
          if (issued == TW'(TOTAL)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && last_frame) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_result_reader.sv
// Bench for acc_result_reader. A full-size instance covers credit, streaming,
// back-pressure, overflow and reset; a reduced instance (4-word frames,
// 16-word memory) covers frame end, done/busy and read-pointer wrap.
// Expected words come from a sequential-address model: every line of credit
// yields the next four addresses, in order, tagged from their frame index.
module tb_acc_result_reader;

  localparam int DW     = 64;
  localparam int BAW    = 16;
  localparam int BWPC   = 28;
  localparam int BTOTAL = 28 * 56 * 64;
  localparam int SAW    = 4;
  localparam int SWPC   = 2;
  localparam int STOTAL = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       b_start, b_wr_line, b_busy, b_done, b_err_ovf;
  logic [1:0] b_dbg_state;
  logic       s_start, s_wr_line, s_busy, s_done, s_err_ovf;
  logic [1:0] s_dbg_state;

  acc_result_reader_if #(.DW(DW), .AW(BAW)) b_bus ();
  acc_result_reader_if #(.DW(DW), .AW(SAW)) s_bus ();

  acc_result_reader #(.DW(DW), .AW(BAW)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .wr_line(b_wr_line),
    .bus(b_bus), .busy(b_busy), .done(b_done), .err_ovf(b_err_ovf),
    .dbg_state(b_dbg_state)
  );

  acc_result_reader #(.DW(DW), .AW(SAW), .WPC(SWPC), .COLS(2), .CHNLS(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .wr_line(s_wr_line),
    .bus(s_bus), .busy(s_busy), .done(s_done), .err_ovf(s_err_ovf),
    .dbg_state(s_dbg_state)
  );

  // Result memories: word content is its own address; garbage when not read.
  always @(posedge clk) b_bus.data_i <= b_bus.ren ? DW'(b_bus.rd_ptr) : {$urandom, $urandom};
  always @(posedge clk) s_bus.data_i <= s_bus.ren ? DW'(s_bus.rd_ptr) : {$urandom, $urandom};

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_f_q[$];   // {last_frame, last_col}
  int n_checks, n_errors;
  int b_model_ptr, b_out_idx, s_model_ptr, s_out_idx;

  task automatic b_expect(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(DW'(b_model_ptr));
      exp_f_q.push_back({b_out_idx == BTOTAL - 1, (b_out_idx % BWPC) == BWPC - 1});
      b_model_ptr = (b_model_ptr + 1) % (1 << BAW);
      b_out_idx   = b_out_idx + 1;
    end
  endtask

  task automatic s_expect(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(DW'(s_model_ptr));
      exp_f_q.push_back({s_out_idx == STOTAL - 1, (s_out_idx % SWPC) == SWPC - 1});
      s_model_ptr = (s_model_ptr + 1) % (1 << SAW);
      s_out_idx   = s_out_idx + 1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    b_start = 0; b_wr_line = 0; b_bus.m_ready = 0;
    s_start = 0; s_wr_line = 0; s_bus.m_ready = 0;
    exp_q.delete(); exp_f_q.delete();
    b_model_ptr = 0; b_out_idx = 0; s_model_ptr = 0; s_out_idx = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({b_bus.ren, b_bus.rd_ptr, b_bus.m_valid, b_bus.m_data, b_bus.m_last_col,
         b_bus.m_last_frame, b_busy, b_done, b_err_ovf} !== '0) begin
      n_errors++;
      $display("FAIL reset_big: outputs %h, expected all zero", {b_bus.ren, b_bus.rd_ptr,
               b_bus.m_valid, b_bus.m_data, b_bus.m_last_col, b_bus.m_last_frame, b_busy, b_done, b_err_ovf});
    end
    n_checks++;
    if ({s_bus.ren, s_bus.rd_ptr, s_bus.m_valid, s_bus.m_data, s_bus.m_last_col,
         s_bus.m_last_frame, s_busy, s_done, s_err_ovf} !== '0) begin
      n_errors++;
      $display("FAIL reset_small: outputs %h, expected all zero", {s_bus.ren, s_bus.rd_ptr,
               s_bus.m_valid, s_bus.m_data, s_bus.m_last_col, s_bus.m_last_frame, s_busy, s_done, s_err_ovf});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({b_bus.ren, b_bus.m_valid, b_busy, s_bus.ren, s_bus.m_valid, s_busy} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_idle: ren/valid/busy %b, expected 000000",
               {b_bus.ren, b_bus.m_valid, b_busy, s_bus.ren, s_bus.m_valid, s_busy});
    end
  endtask

  task automatic test_no_credit();
    @(posedge clk); #1; b_start = 1;
    @(posedge clk); #1; b_start = 0; b_bus.m_ready = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({b_bus.ren, b_busy, b_bus.m_valid} !== 3'b010) begin
        n_errors++;
        $display("FAIL no_credit cycle %0d: ren/busy/valid %b, expected 010", i,
                 {b_bus.ren, b_busy, b_bus.m_valid});
      end
    end
  endtask

  task automatic test_stream();
    int cyc, first_ren, first_valid, first_acc, last_acc;
    logic [DW-1:0] ed;
    logic [1:0] ef;
    first_ren = -1; first_valid = -1; first_acc = -1; last_acc = -1;
    cyc = 0;
    b_bus.m_ready = 1;
    while ((cyc < 7 || exp_q.size() != 0) && cyc < 200) begin
      @(posedge clk); #1;
      b_wr_line = (cyc < 7);
      if (cyc < 7) b_expect(4);
      @(negedge clk);
      if (b_bus.ren && first_ren < 0) first_ren = cyc;
      if (b_bus.m_valid && first_valid < 0) first_valid = cyc;
      if (b_bus.m_valid) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got word %h, expected none", b_bus.m_data);
        end else begin
          ed = exp_q.pop_front(); ef = exp_f_q.pop_front();
          if (b_bus.m_data !== ed || {b_bus.m_last_frame, b_bus.m_last_col} !== ef) begin
            n_errors++;
            $display("FAIL stream_word: got %h flags %b, expected %h flags %b", b_bus.m_data,
                     {b_bus.m_last_frame, b_bus.m_last_col}, ed, ef);
          end
        end
      end
      cyc++;
    end
    b_wr_line = 0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stream_timeout: %0d words missing, expected 0", exp_q.size());
    end
    n_checks++;
    if (first_valid - first_ren != 2) begin
      n_errors++;
      $display("FAIL stream_latency: ren-to-valid %0d cycles, expected 2", first_valid - first_ren);
    end
    n_checks++;
    if (last_acc - first_acc != 27) begin
      n_errors++;
      $display("FAIL stream_rate: 28 words took %0d cycles span, expected 27", last_acc - first_acc);
    end
  endtask

  task automatic test_backpressure();
    int cyc, lines, issued, accepted, max_out;
    bit stalled;
    logic [DW-1:0] hd, ed;
    logic [1:0] hf, ef;
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0; lines = 0; issued = 0; accepted = 0; max_out = 0; stalled = 0;
    hd = '0; hf = '0;
    while ((lines < 27 || exp_q.size() != 0) && cyc < 3000) begin
      @(posedge clk); #1;
      b_wr_line = 0;
      if (lines < 7 || (cyc >= 80 && lines < 27 && $urandom_range(0, 2) == 0)) begin
        b_wr_line = 1;
        lines++;
        b_expect(4);
      end
      b_start = (cyc == 10);
      b_bus.m_ready = (cyc < 80) ? pat[3 - (cyc % 4)] : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (b_bus.m_valid !== 1'b1 || b_bus.m_data !== hd ||
            {b_bus.m_last_frame, b_bus.m_last_col} !== hf) begin
          n_errors++;
          $display("FAIL bp_hold: valid %b data %h flags %b, expected 1 %h %b", b_bus.m_valid,
                   b_bus.m_data, {b_bus.m_last_frame, b_bus.m_last_col}, hd, hf);
        end
      end
      if (b_bus.ren) begin
        issued++;
        if (issued - accepted > max_out) max_out = issued - accepted;
        n_checks++;
        if (issued - accepted > 4) begin
          n_errors++;
          $display("FAIL bp_fifo_room: %0d words outstanding, expected at most 4", issued - accepted);
        end
      end
      if (b_bus.m_valid && b_bus.m_ready) begin
        accepted++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL bp_extra: got word %h, expected none", b_bus.m_data);
        end else begin
          ed = exp_q.pop_front(); ef = exp_f_q.pop_front();
          if (b_bus.m_data !== ed || {b_bus.m_last_frame, b_bus.m_last_col} !== ef) begin
            n_errors++;
            $display("FAIL bp_word: got %h flags %b, expected %h flags %b", b_bus.m_data,
                     {b_bus.m_last_frame, b_bus.m_last_col}, ed, ef);
          end
        end
      end
      stalled = b_bus.m_valid && !b_bus.m_ready;
      hd = b_bus.m_data;
      hf = {b_bus.m_last_frame, b_bus.m_last_col};
      cyc++;
    end
    b_wr_line = 0; b_start = 0; b_bus.m_ready = 1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_timeout: %0d words missing, expected 0", exp_q.size());
    end
    n_checks++;
    if (max_out != 4) begin
      n_errors++;
      $display("FAIL bp_ren_pause: peak outstanding %0d, expected 4", max_out);
    end
  endtask

  task automatic test_small_frame(input int fr);
    int dones, last_acc, start_ptr;
    bit seen_ren;
    logic [DW-1:0] ed;
    logic [1:0] ef;
    dones = 0; last_acc = -100; seen_ren = 0;
    start_ptr = s_model_ptr;
    s_out_idx = 0;
    @(posedge clk); #1; s_wr_line = 1; s_expect(4);
    @(posedge clk); #1; s_wr_line = 0; s_start = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      s_start = (cyc == 2);
      s_bus.m_ready = (cyc > 15) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_bus.ren && !seen_ren) begin
        seen_ren = 1;
        n_checks++;
        if (s_bus.rd_ptr !== SAW'(start_ptr)) begin
          n_errors++;
          $display("FAIL small_rd_ptr frame %0d: first read at %h, expected %h", fr, s_bus.rd_ptr, SAW'(start_ptr));
        end
      end
      if (s_done) begin
        dones++;
        n_checks++;
        if (cyc != last_acc + 1) begin
          n_errors++;
          $display("FAIL small_done_timing frame %0d: done at cycle %0d, expected %0d", fr, cyc, last_acc + 1);
        end
      end
      n_checks++;
      if (s_busy !== (dones == 0)) begin
        n_errors++;
        $display("FAIL small_busy frame %0d cycle %0d: busy %b, expected %b", fr, cyc, s_busy, dones == 0);
      end
      if (s_bus.m_valid && s_bus.m_ready) begin
        last_acc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL small_extra frame %0d: got word %h, expected none", fr, s_bus.m_data);
        end else begin
          ed = exp_q.pop_front(); ef = exp_f_q.pop_front();
          if (s_bus.m_data !== ed || {s_bus.m_last_frame, s_bus.m_last_col} !== ef) begin
            n_errors++;
            $display("FAIL small_word frame %0d: got %h flags %b, expected %h flags %b", fr, s_bus.m_data,
                     {s_bus.m_last_frame, s_bus.m_last_col}, ed, ef);
          end
        end
      end
    end
    s_start = 0;
    n_checks++;
    if (dones != 1 || exp_q.size() != 0 || !seen_ren) begin
      n_errors++;
      $display("FAIL small_frame_end frame %0d: done pulses %0d words left %0d read seen %0d, expected 1 0 1",
               fr, dones, exp_q.size(), seen_ren);
    end
  endtask

  task automatic test_ovf();
    apply_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    b_wr_line = 1;
    repeat (16384) @(posedge clk);
    #1;
    b_wr_line = 0;
    @(negedge clk);
    n_checks++;
    if (b_err_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_exact_full: err_ovf %b at exactly 65536 words, expected 0", b_err_ovf);
    end
    @(posedge clk); #1; b_wr_line = 1;
    @(posedge clk); #1; b_wr_line = 0;
    @(negedge clk);
    n_checks++;
    if (b_err_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_set: err_ovf %b after 16385 lines, expected 1", b_err_ovf);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (b_err_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_sticky: err_ovf %b, expected 1", b_err_ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1; b_start = 1; b_bus.m_ready = 0;
    @(posedge clk); #1; b_start = 0;
    repeat (12) @(negedge clk);
    n_checks++;
    if ({b_bus.m_valid, b_bus.ren, b_busy} !== 3'b101 || b_bus.m_data !== DW'(0)) begin
      n_errors++;
      $display("FAIL mid_run_full: valid/ren/busy %b data %h, expected 101 0",
               {b_bus.m_valid, b_bus.ren, b_busy}, b_bus.m_data);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b_bus.ren, b_bus.rd_ptr, b_bus.m_valid, b_bus.m_data, b_bus.m_last_col,
         b_bus.m_last_frame, b_busy, b_done, b_err_ovf} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: outputs %h, expected all zero", {b_bus.ren, b_bus.rd_ptr,
               b_bus.m_valid, b_bus.m_data, b_bus.m_last_col, b_bus.m_last_frame, b_busy, b_done, b_err_ovf});
    end
    #1;
    rst_n = 1'b1;
    b_bus.m_ready = 1;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({b_bus.ren, b_bus.m_valid, b_busy} !== 3'b000) begin
        n_errors++;
        $display("FAIL post_reset_idle: ren/valid/busy %b, expected 000", {b_bus.ren, b_bus.m_valid, b_busy});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_no_credit();
    test_stream();
    test_backpressure();
    for (int f = 0; f < 5; f++) test_small_frame(f);
    test_ovf();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
